// File: rtl/ser_key_pkg.sv
// Shared types and bus-window constants for the serial key reader.
// The key device lives at BA13=0 / BA12=1 and takes its seed on BA7..BA4.
package ser_key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RECOVER,
        ST_DONE
    } state_e;

    localparam logic WIN_BA13 = 1'b0;
    localparam logic WIN_BA12 = 1'b1;
    localparam int   SEED_LSB = 4;
    localparam int   SEED_W   = 4;

    function automatic logic [13:0] key_addr(input logic seed_en, input logic [SEED_W-1:0] seed);
        logic [13:0] a;
        a     = '0;
        a[13] = WIN_BA13;
        a[12] = WIN_BA12;
        if (seed_en) a[SEED_LSB +: SEED_W] = seed;
        return a;
    endfunction

endpackage

// File: rtl/ser_key_reader_if.sv
// External key bus pins: address, read/write, strobe driven by the reader,
// serial read data returned by the key device.
interface ser_key_reader_if;
    logic [13:0] ba;
    logic        br_w;
    logic        sser_n;
    logic        sdrd;

    modport master (output ba, br_w, sser_n, input sdrd);
    modport slave  (input ba, br_w, sser_n, output sdrd);
endinterface

// File: rtl/ser_key_access_timer.sv
// Phase down-counter for one key access; flags the last cycle of each phase
// and the cycle on which sdrd is captured (last STROBE cycle).
module ser_key_access_timer
    import ser_key_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  state_e state_q_i,
    input  state_e state_d_i,
    output logic   phase_end_o,
    output logic   sample_o
);

    localparam int MAXC = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Reload on every phase entry; RECOVER loads 0 so it lasts exactly one cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d_i != state_q_i) begin
            case (state_d_i)
                ST_SETUP:  cnt_d = CW'(SETUP_CYC - 1);
                ST_STROBE: cnt_d = CW'(STROBE_CYC - 1);
                default:   cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign phase_end_o = (cnt_q == '0);
    assign sample_o    = phase_end_o && (state_q_i == ST_STROBE);

endmodule

// File: rtl/ser_key_reader.sv
// Serial key reader: one seed access then NBITS data accesses, word out with a done pulse.
// Optional SER_KEY_CMP_EN adds expect_i/match_o for an on-chip compare of the result.
//
//   state      | meaning
//   IDLE       | bus parked (ba=0, sser_n=1), waiting for start
//   SETUP      | address valid, sser_n high, SETUP_CYC cycles
//   STROBE     | sser_n low, STROBE_CYC cycles, sdrd taken on the last one
//   RECOVER    | one cycle sser_n high, address held
//   DONE       | one cycle, done pulse, data/match updated
module ser_key_reader
    import ser_key_pkg::*;
#(
    parameter int NBITS      = 16,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [SEED_W-1:0] seed_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [NBITS-1:0]  data_o,
`ifdef SER_KEY_CMP_EN
    input  logic [NBITS-1:0]  expect_i,
    output logic              match_o,
`endif
    ser_key_reader_if.master  bus
);

    localparam int AW = $clog2(NBITS + 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [SEED_W-1:0] seed_q, seed_d;
    logic [NBITS-1:0]  sh_q, sh_d;
    logic [NBITS-1:0]  data_q, data_d;
    logic              abort_pend_q, abort_pend_d;
    logic [13:0]       ba_q, ba_d;
    logic              sser_n_q, sser_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              phase_end, sample;

    ser_key_access_timer #(
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .state_q_i   (state_q),
        .state_d_i   (state_d),
        .phase_end_o (phase_end),
        .sample_o    (sample)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        seed_d       = seed_q;
        sh_d         = sh_q;
        abort_pend_d = abort_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d      = ST_SETUP;
                    seed_d       = seed_i;
                    acc_d        = '0;
                    sh_d         = '0;
                    abort_pend_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (abort_i)        state_d = ST_IDLE;
                else if (phase_end) state_d = ST_STROBE;
            end
            ST_STROBE: begin
                // An abort here still passes through RECOVER so sser_n gets a high cycle.
                if (abort_i) begin
                    state_d      = ST_RECOVER;
                    abort_pend_d = 1'b1;
                end else if (phase_end) begin
                    state_d = ST_RECOVER;
                end
                if (sample && !abort_i && (acc_q != '0))
                    sh_d = (sh_q << 1) | NBITS'(bus.sdrd);
            end
            ST_RECOVER: begin
                if (abort_i || abort_pend_q) begin
                    state_d      = ST_IDLE;
                    abort_pend_d = 1'b0;
                end else if (acc_q == AW'(NBITS)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETUP;
                    acc_d   = acc_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so pins change with the state.
    always_comb begin
        ba_d     = '0;
        if (state_d inside {ST_SETUP, ST_STROBE, ST_RECOVER})
            ba_d = key_addr(acc_d == '0, seed_d);
        sser_n_d = (state_d != ST_STROBE);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        data_d   = (state_d == ST_DONE) ? sh_q : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            seed_q       <= '0;
            sh_q         <= '0;
            data_q       <= '0;
            abort_pend_q <= 1'b0;
            ba_q         <= '0;
            sser_n_q     <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            seed_q       <= seed_d;
            sh_q         <= sh_d;
            data_q       <= data_d;
            abort_pend_q <= abort_pend_d;
            ba_q         <= ba_d;
            sser_n_q     <= sser_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef SER_KEY_CMP_EN
    logic match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  match_q <= 1'b0;
        else if (state_d == ST_DONE) match_q <= (sh_q == expect_i);
    end

    assign match_o = match_q;
`endif

    assign bus.ba     = ba_q;
    assign bus.br_w   = 1'b1;
    assign bus.sser_n = sser_n_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign data_o     = data_q;

endmodule

// File: tb/tb_ser_key_reader.sv
// Randomized bench for ser_key_reader against a cycle-position model of the access sequence.
// Build with +define+SER_KEY_CMP_EN to also exercise the comparator.
module tb_ser_key_reader;

    localparam int NB  = 16;
    localparam int SC  = 2;
    localparam int TC  = 2;
    localparam int ACC = SC + TC + 1;
    localparam int L   = (NB + 1) * ACC + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  seed = 4'h0;
    logic        busy, done;
    logic [15:0] data;
    logic [15:0] last_data = 16'h0;
    logic [15:0] exp_word = 16'h0;
    logic        match;
    int          n_total = 0;
    int          n_bad = 0;

    ser_key_reader_if bus_if ();

    ser_key_reader #(.NBITS(NB), .SETUP_CYC(SC), .STROBE_CYC(TC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .abort_i  (abort),
        .seed_i   (seed),
        .busy_o   (busy),
        .done_o   (done),
        .data_o   (data),
`ifdef SER_KEY_CMP_EN
        .expect_i (exp_word),
        .match_o  (match),
`endif
        .bus      (bus_if)
    );

`ifndef SER_KEY_CMP_EN
    assign match = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected pin values for cycle c (1-based from the start edge) of a transaction.
    function automatic logic exp_sser_n(input int c);
        int p;
        p = (c - 1) % ACC;
        return !(p >= SC && p < SC + TC);
    endfunction

    function automatic logic [13:0] exp_ba(input int c, input logic [3:0] sd);
        return ((c - 1) / ACC == 0) ? (14'h1000 | (14'(sd) << 4)) : 14'h1000;
    endfunction

    // Data access a carries bits[NB-a]: the first sampled bit ends up at the MSB.
    task automatic run_txn(input logic [3:0] sd, input logic [15:0] bits);
        int a;
        int lows;
        logic prev_s;
        lows   = 0;
        prev_s = 1'b1;
        @(negedge clk);
        start = 1'b1;
        seed  = sd;
        bus_if.sdrd = 1'($urandom);
        for (int c = 1; c <= L + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                seed  = 4'($urandom);
            end
            a = (c - 1) / ACC;
            if (c <= L - 1) bus_if.sdrd = (a == 0) ? 1'($urandom) : bits[NB - a];
            if (prev_s && !bus_if.sser_n) lows++;
            prev_s = bus_if.sser_n;
            chk("br_w", bus_if.br_w, 1);
            if (c <= L - 1) begin
                chk("sser_n", bus_if.sser_n, exp_sser_n(c));
                chk("ba", bus_if.ba, exp_ba(c, sd));
                chk("busy", busy, 1);
                chk("done_early", done, 0);
                chk("data_held", data, last_data);
            end else if (c == L) begin
                chk("done", done, 1);
                chk("busy_in_done", busy, 1);
                chk("data", data, bits);
`ifdef SER_KEY_CMP_EN
                chk("match", match, (bits == exp_word));
`endif
            end else begin
                chk("done_after", done, 0);
                chk("busy_after", busy, 0);
                chk("sser_n_idle", bus_if.sser_n, 1);
                chk("ba_idle", bus_if.ba, 0);
            end
        end
        chk("strobe_count", lows, NB + 1);
        last_data = bits;
    endtask

    task automatic run_abort(input int ac);
        logic st;
        st = !exp_sser_n(ac);
        @(negedge clk);
        start = 1'b1;
        seed  = 4'($urandom);
        for (int c = 1; c <= ac + 3; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            abort = (c == ac);
            bus_if.sdrd = 1'($urandom);
            chk("abort_no_done", done, 0);
            chk("abort_data", data, last_data);
            if (c == ac && st) chk("abort_low", bus_if.sser_n, 0);
            if (c == ac + 1) begin
                chk("abort_sser_n", bus_if.sser_n, 1);
                chk("abort_busy1", busy, st);
            end
            if (c >= ac + 2) begin
                chk("abort_idle", busy, 0);
                chk("abort_sser_idle", bus_if.sser_n, 1);
            end
        end
        abort = 1'b0;
    endtask

    task automatic run_reset_mid(input int rc);
        @(negedge clk);
        start = 1'b1;
        seed  = 4'($urandom);
        for (int c = 1; c <= rc; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            bus_if.sdrd = 1'($urandom);
        end
        chk("pre_reset_low", bus_if.sser_n, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_sser_n", bus_if.sser_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", data, 0);
        chk("rst_ba", bus_if.ba, 0);
        last_data = 16'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_b2b(input logic [15:0] bits);
        int lc;
        int a;
        @(negedge clk);
        start = 1'b1;
        seed  = 4'h5;
        for (int c = 1; c <= 2 * L + 2; c++) begin
            @(negedge clk);
            if (c == 2 * L + 1) start = 1'b0;
            lc = (c <= L + 1) ? c : c - (L + 1);
            a  = (lc - 1) / ACC;
            if (lc <= L - 1 && c != L + 1) bus_if.sdrd = (a == 0) ? 1'($urandom) : bits[NB - a];
            chk("b2b_done", done, (c == L) || (c == 2 * L + 1));
            if (c == L || c == 2 * L + 1) chk("b2b_data", data, bits);
            if (c == L + 1) chk("b2b_busy_gap", busy, 0);
            if (c == L + 2) chk("b2b_restart", busy, 1);
        end
        chk("b2b_end_idle", busy, 0);
        last_data = bits;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus_if.sdrd = 1'b0;
        #12;
        chk("reset_sser_n", bus_if.sser_n, 1);
        chk("reset_br_w", bus_if.br_w, 1);
        chk("reset_ba", bus_if.ba, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_data", data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        exp_word = 16'hAAAA;
        run_txn(4'hA, 16'hAAAA);
        exp_word = 16'hAAAB;
        run_txn(4'hA, 16'hAAAA);
        run_txn(4'($urandom), 16'hFFFF);

        run_abort(5 * ACC + SC + 1);
        run_abort(L - 1);
        for (int i = 0; i < 3; i++) run_abort($urandom_range(1, L - 1));

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", busy, 0);

        run_reset_mid(8 * ACC + SC + 1);
        run_txn(4'($urandom), 16'($urandom));

        run_b2b(16'($urandom));

        for (int i = 0; i < 3; i++) begin
            exp_word = 16'($urandom);
            run_txn(4'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ser_key_reader.md
# ser_key_reader

Bus-side initiator for the serial key device in the cartridge window, i.e. the reader that talks to the key responder. On `start` it runs one seed access, then `NBITS` data accesses. The seed access drives a 4-bit seed onto BA7..BA4. Each data access samples one bit on `sdrd`. The collected bits are presented as a parallel word with a one-cycle `done` pulse. It sits between the host control logic and the external key bus pins (BA13..BA0, BR_W, SSER).

## Interface
- `NBITS`, 16: number of data bits collected per transaction (1..32).
- `SETUP_CYC`, 2: cycles the address and `br_w` are held with `sser_n` high before the strobe (≥1).
- `STROBE_CYC`, 2: cycles `sser_n` is held low per access (≥1).

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a transaction; sampled only in IDLE.
- `abort`  in  1  terminate the current transaction without `done`.
- `seed`  in  4  seed value; captured on the `start` cycle.
- `sdrd`  in  1  serial data from the key device.
- `ba`  out  14  bus address BA13..BA0.
- `br_w`  out  1  read/write, 1 = read; always 1 in this block.
- `sser_n`  out  1  active-low key select/strobe.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `data`  out  `NBITS`  collected word; first sampled bit is at MSB.

## Operation
- States:
  - IDLE
  - SETUP: `sser_n`=1, address valid for `SETUP_CYC` cycles.
  - STROBE: `sser_n`=0 for `STROBE_CYC` cycles.
  - RECOVER: one cycle, `sser_n`=1, address still held.
  - DONE: one cycle.
- IDLE → SETUP when `start`=1. On that edge capture `seed` and clear the bit counter.
- SETUP → STROBE when the phase counter reaches `SETUP_CYC`.
- STROBE → RECOVER when the phase counter reaches `STROBE_CYC`.
- RECOVER → SETUP while accesses remain. RECOVER → DONE after access number `NBITS`+1. DONE → IDLE.
- Access 0 is the seed access. It drives `ba` = BA13=0, BA12=1, BA7..BA4 = captured seed, all other bits 0. Its `sdrd` is not sampled.
- Accesses 1..`NBITS` are data accesses. They drive BA13=0, BA12=1, all other bits 0. `sdrd` is sampled on the last STROBE cycle and shifted left into the internal shift register at bit 0.
- `data` is loaded from the shift register on entry to DONE and held until the next DONE. It is never partially updated.
- In IDLE the outputs are `ba`=0, `br_w`=1, `sser_n`=1.
- `abort`:
  - In SETUP or RECOVER: go to IDLE next edge.
  - In STROBE: go to RECOVER next edge, then IDLE. `sser_n` never drops from low straight to IDLE without one high RECOVER cycle.
  - In all cases: no `done`, `data` unchanged.
- `abort` has priority over normal progression. `start` is ignored in every state except IDLE. `start` and `abort` together in IDLE: `abort` wins and the block stays IDLE.
- Reset values: state IDLE, `ba`=0, `br_w`=1, `sser_n`=1, `busy`=0, `done`=0, `data`=0, counters 0.
- Asserting `rst_n` mid-access forces `sser_n` high immediately (asynchronous).

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Each access lasts `SETUP_CYC`+`STROBE_CYC`+1 cycles.
- `done` is high in cycle L = (`NBITS`+1)·(`SETUP_CYC`+`STROBE_CYC`+1)+1 counted from the `start` edge. That edge is cycle 0, and `busy` is high from cycle 1.
- `busy`=1 during DONE and drops in the following cycle. A new `start` is accepted on the first IDLE cycle, giving back-to-back spacing of L+1 cycles.
- `sdrd` must be stable at the rising edge ending the last STROBE cycle.

## Configuration
- `SER_KEY_CMP_EN` defined:
  - Adds input `expect[NBITS-1:0]` and output `match`.
  - `match` is registered on entry to DONE as (shift register == `expect`) and held with `data`.
  - `match` resets to 0.
- `SER_KEY_CMP_EN` undefined: neither port exists and no comparator logic is built.

## Structure
- `ser_key_pkg` holds:
  - the state enum;
  - window constants BA13=0 and BA12=1;
  - the seed field LSB position (4) and width (4).
- Sub-module `ser_key_access_timer`: the phase counter plus SETUP/STROBE/RECOVER sequencing. It reports end-of-phase and sample strobes to the top-level FSM, which owns the bit counter, shift register and bus outputs.

## Test plan
All scenarios use `NBITS`=16, `SETUP_CYC`=2, `STROBE_CYC`=2.
- **Alternating data:** `seed`=4'hA, `sdrd` alternating 1,0 starting at data access 1 → `ba`=14'h10A0 during access 0 and 14'h1000 afterwards; `done` at cycle 86; `data`=16'hAAAA.
- **Stuck-high `sdrd`:** `sdrd` tied 1 → `data`=16'hFFFF; exactly 17 low pulses on `sser_n`, each 2 cycles wide and separated by ≥3 high cycles.
- **Abort in STROBE:** `abort` pulsed during STROBE of data access 5 → `sser_n` high on the next cycle, IDLE one cycle later, no `done`, `data` keeps its previous value.
- **Reset mid-op and restart:** `rst_n` low mid-transaction → `sser_n`=1 and `busy`=0 immediately; a fresh `start` after release completes normally in 86 cycles.
- **Start while busy:** `start` held high throughout → second transaction begins on the first IDLE cycle; `done` pulses 87 cycles apart.
- **Comparator (with `SER_KEY_CMP_EN`):** `expect`=16'hAAAA with the alternating pattern → `match`=1; `expect`=16'hAAAB → `match`=0.
